data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Two-master arbiter that shares the single-port data memory between master 0 (CPU load/store unit) and master 1 (DMA/debug port). It selects one request at a time with round-robin fairness and forwards it to the memory as a single-cycle request pulse. It returns the memory's acknowledge and read data only to the granted master. A watchdog terminates a transaction that never receives an acknowledge, and reports it as an error.

Parameters:
TIMEOUT, 15, maximum WAIT cycles without mem_ack before the arbiter returns an error ack; legal range 1..255.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
m0_request  in  1  master 0 request, level; held high until m0_ack
m0_address  in  32  master 0 byte address
m0_write  in  1  master 0 write (1) / read (0)
m0_wstrb  in  4  master 0 byte enables
m0_wdata  in  32  master 0 write data
m0_rdata  out  32  master 0 read data, valid with m0_ack, else 0
m0_ack  out  1  master 0 one-cycle completion pulse
m0_error  out  1  master 0 timeout flag, valid with m0_ack
m1_*  same set as m0_*, for master 1
mem_request  out  1  memory request pulse
mem_address  out  32  registered address to memory
mem_write  out  1  registered write flag
mem_wstrb  out  4  registered byte enables
mem_wdata  out  32  registered write data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory acknowledge, arrives one cycle after mem_request
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n). The polarity and synchronicity are fixed.
- Reset values: state=IDLE, mem_request=0, mem_address/mem_wdata=0, mem_write=0, mem_wstrb=0, last_grant=1 (so master 0 wins the first tie), watchdog counter=0, busy=0. All m*_ack/m*_error outputs are 0 and all m*_rdata outputs are 0.
- Master rule: address, write, wstrb and wdata stay stable while request is high. The master drops request on the clock edge where it sees ack. request=1 on the cycle after ack starts a new transaction.
- IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant that master.
  - Both requests high: grant the master that is not last_grant.
  - On grant: register the winner's address/write/wstrb/wdata onto the mem_* outputs, store grant_id, go to ISSUE.
- ISSUE: mem_request=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: mem_request=0.
  - mem_ack=1: assert m{grant_id}_ack=1 combinationally in the same cycle, with m{grant_id}_rdata=mem_rdata and error=0. Set last_grant=grant_id. Go to IDLE.
  - mem_ack=0: increment the watchdog counter. If the counter reaches TIMEOUT, pulse m{grant_id}_ack=1 with m{grant_id}_error=1 and rdata=0, set last_grant=grant_id, go to IDLE.
  - mem_ack and timeout in the same cycle: the ack wins and error=0.
- Latency: request in cycle N, mem_request in N+1, mem_ack and master ack in N+2. Peak throughput is one transaction per 3 cycles.
- The non-granted master always sees ack=0, error=0 and rdata=0.
- mem_ack arriving in IDLE or ISSUE is a stray ack and is ignored; no master ack is produced.
- Reset mid-transaction forces IDLE immediately. A memory ack arriving after reset is ignored.
- The mem_* address/data outputs hold their last values while in IDLE; only mem_request qualifies them.
- The watchdog counter is 8 bits and saturates; it is only active in WAIT.

Test Plan:
- Single read: reset, m0 read at 0x10 with memory word 0xDEADBEEF -> mem_request pulses in cycle 1; m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 2; m1 outputs stay 0.
- Write strobes: m1 write to 0x20, wstrb=4'b0101, wdata=0xAABBCCDD -> mem_write=1, mem_wstrb=0101 and mem_wdata=0xAABBCCDD during ISSUE; m1_ack pulses two cycles after request.
- Contention: both masters request continuously from reset -> grants alternate 0,1,0,1 over 4 transactions, each ack 3 cycles apart, no master served twice in a row.
- Timeout: TIMEOUT=3, memory model never acks -> m0_ack=1 with m0_error=1 and m0_rdata=0 on the 3rd WAIT cycle; the arbiter then serves a pending m1 request normally.
- Stray and late ack: mem_ack pulsed while in IDLE -> no m*_ack. Assert reset_n=0 during WAIT, then pulse mem_ack after release -> no m*_ack, busy=0.
- Back-to-back: m0 re-asserts request on the cycle after its ack -> next mem_request exactly 3 cycles after the previous one.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU LSU (m0) and DMA/debug (m1).
// Registers the winning request onto mem_*, pulses mem_request once, and routes ack/rdata back with a watchdog.
module data_memory_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_request,
  input  logic [31:0] m0_address,
  input  logic        m0_write,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_error,
  input  logic        m1_request,
  input  logic [31:0] m1_address,
  input  logic        m1_write,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_error,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  logic [1:0] state;
  logic       grant_id;
  logic       last_grant;
  logic [7:0] wd_count;
  logic [8:0] wd_next;
  logic       pick;
  logic       ack_ok;
  logic       timeout;
  logic       done;

  always_comb begin
    pick = 1'b0;
    if (m0_request && m1_request) pick = ~last_grant;
    else if (m1_request)          pick = 1'b1;
    wd_next = {1'b0, wd_count} + 9'd1;
    ack_ok  = (state == WAIT) && mem_ack;
    // A real ack in the same cycle as expiry takes precedence over the error.
    timeout = (state == WAIT) && !mem_ack && (wd_next >= TIMEOUT_LIM);
    done    = ack_ok || timeout;
  end

  assign mem_request = (state == ISSUE);
  assign busy        = (state != IDLE);

  assign m0_ack   = done && !grant_id;
  assign m1_ack   = done && grant_id;
  assign m0_error = timeout && !grant_id;
  assign m1_error = timeout && grant_id;
  assign m0_rdata = (ack_ok && !grant_id) ? mem_rdata : '0;
  assign m1_rdata = (ack_ok && grant_id) ? mem_rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      wd_count    <= '0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_request || m1_request) begin
            grant_id    <= pick;
            mem_address <= pick ? m1_address : m0_address;
            mem_write   <= pick ? m1_write   : m0_write;
            mem_wstrb   <= pick ? m1_wstrb   : m0_wstrb;
            mem_wdata   <= pick ? m1_wdata   : m0_wdata;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wd_count <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (done) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end else if (wd_count != '1) begin
            wd_count <= wd_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed-vector bench for data_memory_arbiter (TIMEOUT=3): inputs change 2ns after each rising edge,
// outputs are compared 1ns later, well clear of the next edge.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_request = 1'b0, m0_write = 1'b0, m0_ack, m0_error;
  logic [31:0] m0_address = '0, m0_wdata = '0, m0_rdata;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_request = 1'b0, m1_write = 1'b0, m1_ack, m1_error;
  logic [31:0] m1_address = '0, m1_wdata = '0, m1_rdata;
  logic [3:0]  m1_wstrb = '0;
  logic        mem_request, mem_write, busy;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_address, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter #(.TIMEOUT(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_request(m0_request), .m0_address(m0_address), .m0_write(m0_write), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_error(m0_error),
    .m1_request(m1_request), .m1_address(m1_address), .m1_write(m1_write), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_error(m1_error),
    .mem_request(mem_request), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    m0_request = 1'b0; m1_request = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL reset_mem_request got %b exp 0", mem_request); end
    checks++; if ({mem_address, mem_wdata, mem_write, mem_wstrb} !== '0) begin errors++; $display("FAIL reset_mem_regs got %h/%h/%b/%b exp 0", mem_address, mem_wdata, mem_write, mem_wstrb); end
    checks++; if ({m0_ack, m0_error, m1_ack, m1_error} !== 4'b0) begin errors++; $display("FAIL reset_acks got %b%b%b%b exp 0000", m0_ack, m0_error, m1_ack, m1_error); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", m0_rdata, m1_rdata); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_request = 1'b1; m0_address = 32'h10; m0_write = 1'b0; m0_wstrb = 4'hF;
    #1;
    checks++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_c0 got ack=%b busy=%b exp 0 0", m0_ack, busy); end
    step(); #1;
    checks++; if (mem_request !== 1'b1 || mem_address !== 32'h10 || mem_write !== 1'b0) begin errors++; $display("FAIL read_issue got req=%b addr=%h wr=%b exp 1 00000010 0", mem_request, mem_address, mem_write); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b exp 1", busy); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL read_wait_req got %b exp 0", mem_request); end
    checks++; if (m0_ack !== 1'b1 || m0_error !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_ack got ack=%b err=%b rdata=%h exp 1 0 deadbeef", m0_ack, m0_error, m0_rdata); end
    checks++; if (m1_ack !== 1'b0 || m1_error !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL read_m1_quiet got ack=%b err=%b rdata=%h exp 0 0 0", m1_ack, m1_error, m1_rdata); end
    step();
    m0_request = 1'b0; mem_ack = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL read_idle got busy=%b ack=%b rdata=%h exp 0 0 0", busy, m0_ack, m0_rdata); end
    checks++; if (mem_address !== 32'h10) begin errors++; $display("FAIL read_hold_addr got %h exp 00000010", mem_address); end
  endtask

  task automatic test_write_strobe();
    m1_request = 1'b1; m1_address = 32'h20; m1_write = 1'b1; m1_wstrb = 4'b0101; m1_wdata = 32'hAABBCCDD;
    step(); #1;
    checks++; if (mem_request !== 1'b1 || mem_address !== 32'h20) begin errors++; $display("FAIL wr_issue got req=%b addr=%h exp 1 00000020", mem_request, mem_address); end
    checks++; if (mem_write !== 1'b1 || mem_wstrb !== 4'b0101 || mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL wr_fields got wr=%b strb=%b wdata=%h exp 1 0101 aabbccdd", mem_write, mem_wstrb, mem_wdata); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    checks++; if (m1_ack !== 1'b1 || m1_error !== 1'b0 || m1_rdata !== 32'h12345678) begin errors++; $display("FAIL wr_ack got ack=%b err=%b rdata=%h exp 1 0 12345678", m1_ack, m1_error, m1_rdata); end
    checks++; if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_m0_quiet got ack=%b rdata=%h exp 0 0", m0_ack, m0_rdata); end
    step();
    m1_request = 1'b0; m1_write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_grant;
    do_reset();
    m0_request = 1'b1; m0_address = 32'h100; m0_write = 1'b0;
    m1_request = 1'b1; m1_address = 32'h200; m1_write = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_grant = t[0];
      #1;
      checks++; if (busy !== 1'b0 || mem_request !== 1'b0) begin errors++; $display("FAIL cont_idle_%0d got busy=%b req=%b exp 0 0", t, busy, mem_request); end
      step(); #1;
      checks++; if (mem_request !== 1'b1 || mem_address !== (exp_grant ? 32'h200 : 32'h100)) begin errors++; $display("FAIL cont_grant_%0d got req=%b addr=%h exp master %0d", t, mem_request, mem_address, exp_grant); end
      step();
      mem_ack = 1'b1; mem_rdata = 32'hC0DE0000 + t;
      #1;
      checks++; if (m0_ack !== !exp_grant || m1_ack !== exp_grant) begin errors++; $display("FAIL cont_ack_%0d got m0=%b m1=%b exp master %0d", t, m0_ack, m1_ack, exp_grant); end
      step();
      mem_ack = 1'b0;
    end
    m0_request = 1'b0; m1_request = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    m0_request = 1'b1; m0_address = 32'h300;
    m1_request = 1'b1; m1_address = 32'h400;
    mem_rdata = 32'hFFFFFFFF;
    step(); #1;
    checks++; if (mem_address !== 32'h300) begin errors++; $display("FAIL to_grant got %h exp 00000300", mem_address); end
    for (int w = 1; w <= 2; w++) begin
      step(); #1;
      checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait_%0d got m0=%b m1=%b busy=%b exp 0 0 1", w, m0_ack, m1_ack, busy); end
    end
    step(); #1;
    checks++; if (m0_ack !== 1'b1 || m0_error !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("FAIL to_expire got ack=%b err=%b rdata=%h exp 1 1 0", m0_ack, m0_error, m0_rdata); end
    checks++; if (m1_ack !== 1'b0 || m1_error !== 1'b0) begin errors++; $display("FAIL to_m1_quiet got ack=%b err=%b exp 0 0", m1_ack, m1_error); end
    step();
    m0_request = 1'b0;
    step(); #1;
    checks++; if (mem_request !== 1'b1 || mem_address !== 32'h400) begin errors++; $display("FAIL to_m1_issue got req=%b addr=%h exp 1 00000400", mem_request, mem_address); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    checks++; if (m1_ack !== 1'b1 || m1_error !== 1'b0 || m1_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL to_m1_ack got ack=%b err=%b rdata=%h exp 1 0 0badf00d", m1_ack, m1_error, m1_rdata); end
    step();
    m1_request = 1'b0; mem_ack = 1'b0;
    // ack landing on the final watchdog cycle must complete cleanly
    m0_request = 1'b1; m0_address = 32'h304;
    step(); step(); step(); step();
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1;
    checks++; if (m0_ack !== 1'b1 || m0_error !== 1'b0 || m0_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL to_ack_wins got ack=%b err=%b rdata=%h exp 1 0 5a5a5a5a", m0_ack, m0_error, m0_rdata); end
    step();
    m0_request = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_stray_ack();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stray_idle got m0=%b m1=%b busy=%b exp 0 0 0", m0_ack, m1_ack, busy); end
    m0_request = 1'b1; m0_address = 32'h500;
    step(); #1;
    checks++; if (mem_request !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL stray_issue got req=%b ack=%b exp 1 0", mem_request, m0_ack); end
    step();
    mem_ack = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL stray_wait got busy=%b ack=%b exp 1 0", busy, m0_ack); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mem_request !== 1'b0) begin errors++; $display("FAIL async_reset got busy=%b req=%b exp 0 0", busy, mem_request); end
    step();
    reset_n = 1'b1; m0_request = 1'b0; mem_ack = 1'b1;
    #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL late_ack got m0=%b m1=%b busy=%b rdata=%h exp 0 0 0 0", m0_ack, m1_ack, busy, m0_rdata); end
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int first_req;
    int second_req;
    do_reset();
    first_req = -1; second_req = -1;
    m0_request = 1'b1; m0_address = 32'h40;
    for (cyc = 1; cyc <= 8; cyc++) begin
      step();
      mem_ack = 1'b0;
      if (cyc == 3) m0_address = 32'h44;
      if (cyc == 6) m0_request = 1'b0;
      #1;
      if (mem_request && first_req < 0) first_req = cyc;
      else if (mem_request && second_req < 0) second_req = cyc;
      if (busy && !mem_request) begin
        mem_ack = 1'b1;
        #1;
        checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_c%0d got %b exp 1", cyc, m0_ack); end
      end
    end
    checks++; if (first_req !== 1) begin errors++; $display("FAIL b2b_first got cycle %0d exp 1", first_req); end
    checks++; if (second_req !== 4) begin errors++; $display("FAIL b2b_second got cycle %0d exp 4", second_req); end
    checks++; if (mem_address !== 32'h44) begin errors++; $display("FAIL b2b_addr got %h exp 00000044", mem_address); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_strobe();
    test_contention();
    test_timeout();
    test_stray_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
